// File: rtl/writeback_queue_pkg.sv
// writeback_queue shared types: register number, data word, queue entry.
// Optional build macro used by this slice: WB_PENDING_MASK_EN.
package kl_pkg;
  localparam int NUM_REGS = 8;

  typedef logic [2:0]  reg_num_t;
  typedef logic [15:0] word_t;

  typedef struct packed {
    reg_num_t num;
    word_t    data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Producer/regfile handshake bundle for writeback_queue.
// pending_mask_out exists only under WB_PENDING_MASK_EN.
interface writeback_queue_if #(
  parameter int DEPTH = 4
);
  import kl_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid_in;
  reg_num_t      alu_num_in;
  word_t         alu_data_in;
  logic          alu_ready_out;
  logic          mem_valid_in;
  reg_num_t      mem_num_in;
  word_t         mem_data_in;
  logic          mem_ready_out;
  logic          write0_out;
  logic          write1_out;
  reg_num_t      num_write0_out;
  reg_num_t      num_write1_out;
  word_t         data_write0_out;
  word_t         data_write1_out;
  logic [CW-1:0] count_out;
`ifdef WB_PENDING_MASK_EN
  logic [NUM_REGS-1:0] pending_mask_out;
`endif

`ifdef WB_PENDING_MASK_EN
  modport master (
    output alu_valid_in, alu_num_in, alu_data_in,
    output mem_valid_in, mem_num_in, mem_data_in,
    input  alu_ready_out, mem_ready_out,
    input  write0_out, write1_out,
    input  num_write0_out, num_write1_out,
    input  data_write0_out, data_write1_out,
    input  count_out, pending_mask_out
  );
  modport slave (
    input  alu_valid_in, alu_num_in, alu_data_in,
    input  mem_valid_in, mem_num_in, mem_data_in,
    output alu_ready_out, mem_ready_out,
    output write0_out, write1_out,
    output num_write0_out, num_write1_out,
    output data_write0_out, data_write1_out,
    output count_out, pending_mask_out
  );
`else
  modport master (
    output alu_valid_in, alu_num_in, alu_data_in,
    output mem_valid_in, mem_num_in, mem_data_in,
    input  alu_ready_out, mem_ready_out,
    input  write0_out, write1_out,
    input  num_write0_out, num_write1_out,
    input  data_write0_out, data_write1_out,
    input  count_out
  );
  modport slave (
    input  alu_valid_in, alu_num_in, alu_data_in,
    input  mem_valid_in, mem_num_in, mem_data_in,
    output alu_ready_out, mem_ready_out,
    output write0_out, write1_out,
    output num_write0_out, num_write1_out,
    output data_write0_out, data_write1_out,
    output count_out
  );
`endif
endinterface

// File: rtl/writeback_queue.sv
// Dual-producer writeback FIFO draining up to two regfile writes per cycle.
// WB_PENDING_MASK_EN adds a per-register pending mask output.
module writeback_queue
  import kl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_rdy;
  logic          w_alu_go;
  logic          w_mem_go;
  logic          w_wr0;
  logic          w_wr1;
  logic [PW-1:0] w_head1;
  logic [PW-1:0] w_tail1;
  logic [CW-1:0] w_n_enq;
  logic [CW-1:0] w_n_drn;
  wb_entry_t     w_e0;
  wb_entry_t     w_e1;

  // ready looks only at registered count, so two entries always fit
  assign w_rdy    = (r_count <= CW'(DEPTH - 2));
  assign w_alu_go = bus.alu_valid_in & w_rdy;
  assign w_mem_go = bus.mem_valid_in & w_rdy;

  assign w_head1  = r_head + 1'b1;
  assign w_tail1  = r_tail + PW'(w_alu_go);
  assign w_e0     = r_mem[r_head];
  assign w_e1     = r_mem[w_head1];

  // same-register pair drains one at a time to keep program order
  assign w_wr0    = (r_count != '0);
  assign w_wr1    = (r_count >= CW'(2)) && (w_e1.num != w_e0.num);

  assign w_n_enq  = CW'(w_alu_go) + CW'(w_mem_go);
  assign w_n_drn  = CW'(w_wr0) + CW'(w_wr1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_n_drn);
      r_tail  <= r_tail + PW'(w_n_enq);
      r_count <= r_count + w_n_enq - w_n_drn;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alu_go)
      r_mem[r_tail] <= {bus.alu_num_in, bus.alu_data_in};
    if (w_mem_go)
      r_mem[w_tail1] <= {bus.mem_num_in, bus.mem_data_in};
  end

  assign bus.alu_ready_out   = w_rdy;
  assign bus.mem_ready_out   = w_rdy;
  assign bus.write0_out      = w_wr0;
  assign bus.write1_out      = w_wr1;
  assign bus.num_write0_out  = w_e0.num;
  assign bus.num_write1_out  = w_e1.num;
  assign bus.data_write0_out = w_e0.data;
  assign bus.data_write1_out = w_e1.data;
  assign bus.count_out       = r_count;

`ifdef WB_PENDING_MASK_EN
  logic [NUM_REGS-1:0] w_mask;
  logic [PW-1:0]       w_off;

  always_comb begin
    w_mask = '0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if (CW'(w_off) < r_count)
        w_mask[r_mem[i].num] = 1'b1;
    end
  end

  assign bus.pending_mask_out = w_mask;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: vector table, corner sequences,
// and a queue-based reference model under random / back-to-back traffic.
module tb_writeback_queue;
  import kl_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_queue_if #(.DEPTH(DEPTH)) bus();
  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] dut_rf [NUM_REGS] = '{default: 16'h0};
  int wcnt = 0;

  // regfile as seen through the write ports
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.write0_out) dut_rf[bus.num_write0_out] <= bus.data_write0_out;
      if (bus.write1_out) dut_rf[bus.num_write1_out] <= bus.data_write1_out;
      wcnt <= wcnt + int'(bus.write0_out) + int'(bus.write1_out);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit av, reg_num_t an, word_t ad,
                       bit mv, reg_num_t mn, word_t md);
    bus.alu_valid_in = av;
    bus.alu_num_in   = an;
    bus.alu_data_in  = ad;
    bus.mem_valid_in = mv;
    bus.mem_num_in   = mn;
    bus.mem_data_in  = md;
  endtask

  task automatic wait_empty();
    int k = 0;
    while (bus.count_out != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_done", 32'(bus.count_out), 0);
  endtask

  typedef struct {
    bit       av;
    reg_num_t an;
    word_t    ad;
    bit       mv;
    reg_num_t mn;
    word_t    md;
    bit       w0;
    reg_num_t n0;
    word_t    d0;
    bit       w1;
    reg_num_t n1;
    word_t    d1;
    int       cnt;
    int       pc;
    word_t    pd0;
  } vec_t;

  vec_t tbl [5];

  task automatic run_model(int ncyc, bit b2b, output int pairs);
    wb_entry_t   q[$];
    logic [15:0] ref_rf [NUM_REGS];
    bit          av, mv, rdy, e0, e1, aa, ma;
    reg_num_t    an, mn;
    word_t       ad, md;
    logic [7:0]  em;
    pairs = 0;
    foreach (ref_rf[r]) ref_rf[r] = dut_rf[r];
    av = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
    mv = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
    an = 3'($urandom_range(0, 7));
    mn = 3'($urandom_range(0, 7));
    ad = 16'($urandom);
    md = 16'($urandom);
    for (int c = 0; c < ncyc; c++) begin
      drive(av, an, ad, mv, mn, md);
      @(negedge clk);
      rdy = (q.size() <= DEPTH - 2);
      e0  = (q.size() >= 1);
      e1  = (q.size() >= 2) && (q[1].num != q[0].num);
      chk("m_alu_rdy", 32'(bus.alu_ready_out), 32'(rdy));
      chk("m_mem_rdy", 32'(bus.mem_ready_out), 32'(rdy));
      chk("m_count", 32'(bus.count_out), q.size());
      chk("m_w0", 32'(bus.write0_out), 32'(e0));
      if (e0) begin
        chk("m_n0", 32'(bus.num_write0_out), 32'(q[0].num));
        chk("m_d0", 32'(bus.data_write0_out), 32'(q[0].data));
      end
      chk("m_w1", 32'(bus.write1_out), 32'(e1));
      if (e1) begin
        chk("m_n1", 32'(bus.num_write1_out), 32'(q[1].num));
        chk("m_d1", 32'(bus.data_write1_out), 32'(q[1].data));
      end
      em = '0;
      foreach (q[j]) em[q[j].num] = 1'b1;
`ifdef WB_PENDING_MASK_EN
      chk("m_mask", 32'(bus.pending_mask_out), 32'(em));
`endif
      if (e0) begin
        ref_rf[q[0].num] = q[0].data;
        void'(q.pop_front());
      end
      if (e1) begin
        ref_rf[q[0].num] = q[0].data;
        void'(q.pop_front());
      end
      aa = av && rdy;
      ma = mv && rdy;
      if (aa) q.push_back({an, ad});
      if (ma) q.push_back({mn, md});
      if (aa && ma) pairs++;
      @(posedge clk); #1;
      if (aa || !av) begin
        av = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
        an = 3'($urandom_range(0, 7));
        ad = 16'($urandom);
      end
      if (ma || !mv) begin
        mv = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
        mn = b2b ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
        md = 16'($urandom);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    foreach (q[j]) ref_rf[q[j].num] = q[j].data;
    wait_empty();
    @(posedge clk); #1;
    for (int r = 0; r < NUM_REGS; r++)
      chk($sformatf("m_rf%0d", r), 32'(dut_rf[r]), 32'(ref_rf[r]));
  endtask

  initial begin
    int    pairs;
    int    w;
    bit    acc;
    bit    seen_nr;
    word_t last;
    word_t fa, fm;

    tbl[0] = '{1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000,
               1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 1, 0, 16'h0000};
    tbl[1] = '{1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555,
               1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, 2, 0, 16'h0000};
    tbl[2] = '{1, 3'd4, 16'h0001, 1, 3'd4, 16'h0002,
               1, 3'd4, 16'h0001, 0, 3'd0, 16'h0000, 2, 1, 16'h0002};
    tbl[3] = '{0, 3'd0, 16'h0000, 1, 3'd7, 16'hBEEF,
               1, 3'd7, 16'hBEEF, 0, 3'd0, 16'h0000, 1, 0, 16'h0000};
    tbl[4] = '{1, 3'd0, 16'h0000, 1, 3'd5, 16'hFFFF,
               1, 3'd0, 16'h0000, 1, 3'd5, 16'hFFFF, 2, 0, 16'h0000};

    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_w0", 32'(bus.write0_out), 0);
    chk("rst_w1", 32'(bus.write1_out), 0);
    chk("rst_count", 32'(bus.count_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_alu_rdy", 32'(bus.alu_ready_out), 1);
    chk("rel_mem_rdy", 32'(bus.mem_ready_out), 1);
    chk("rel_count", 32'(bus.count_out), 0);
    chk("rel_w0", 32'(bus.write0_out), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].an, tbl[i].ad, tbl[i].mv, tbl[i].mn, tbl[i].md);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("v%0d_w0", i), 32'(bus.write0_out), 32'(tbl[i].w0));
      chk($sformatf("v%0d_n0", i), 32'(bus.num_write0_out), 32'(tbl[i].n0));
      chk($sformatf("v%0d_d0", i), 32'(bus.data_write0_out), 32'(tbl[i].d0));
      chk($sformatf("v%0d_w1", i), 32'(bus.write1_out), 32'(tbl[i].w1));
      if (tbl[i].w1) begin
        chk($sformatf("v%0d_n1", i), 32'(bus.num_write1_out), 32'(tbl[i].n1));
        chk($sformatf("v%0d_d1", i), 32'(bus.data_write1_out), 32'(tbl[i].d1));
      end
      chk($sformatf("v%0d_cnt", i), 32'(bus.count_out), tbl[i].cnt);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pcnt", i), 32'(bus.count_out), tbl[i].pc);
      chk($sformatf("v%0d_pw0", i), 32'(bus.write0_out), 32'(tbl[i].pc != 0));
      if (tbl[i].pc != 0)
        chk($sformatf("v%0d_pd0", i), 32'(bus.data_write0_out), 32'(tbl[i].pd0));
      wait_empty();
    end
    @(posedge clk); #1;
    chk("order_r4", 32'(dut_rf[4]), 32'h0002);

    // fill with same-register pairs so only one entry drains per cycle
    fa = 16'h0011;
    fm = 16'h0022;
    last = 16'h0;
    seen_nr = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 3'd6, fa, 1, 3'd6, fm);
      @(negedge clk);
      chk("fill_cnt_max", 32'(bus.count_out <= DEPTH), 1);
      acc = bus.alu_ready_out;
      if (!acc) seen_nr = 1;
      @(posedge clk); #1;
      if (acc) begin
        last = fm;
        fa = fa + 16'h0100;
        fm = fm + 16'h0100;
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("fill_not_ready_seen", 32'(seen_nr), 1);
    wait_empty();
    @(posedge clk); #1;
    chk("fill_r6", 32'(dut_rf[6]), 32'(last));

    // reset with three entries queued
    drive(1, 3'd1, 16'hA001, 1, 3'd1, 16'hA002);
    @(posedge clk); #1;
    drive(1, 3'd1, 16'hA003, 1, 3'd1, 16'hA004);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("mid_count", 32'(bus.count_out), 3);
    chk("mid_w0", 32'(bus.write0_out), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_w0", 32'(bus.write0_out), 0);
    chk("arst_w1", 32'(bus.write1_out), 0);
    chk("arst_count", 32'(bus.count_out), 0);
`ifdef WB_PENDING_MASK_EN
    chk("arst_mask", 32'(bus.pending_mask_out), 0);
`endif
    @(posedge clk);
    @(negedge clk);
    w = wcnt;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arel_alu_rdy", 32'(bus.alu_ready_out), 1);
    chk("arel_mem_rdy", 32'(bus.mem_ready_out), 1);
    chk("arel_count", 32'(bus.count_out), 0);
    chk("arel_w0", 32'(bus.write0_out), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("arel_no_stale", wcnt, w);

    run_model(8 * DEPTH, 1'b1, pairs);
    chk("wrap_pairs", 32'(pairs >= 3 * DEPTH), 1);
    run_model(400, 1'b0, pairs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered writeback entries; legal values are powers of two, 4..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 alu_valid_in  input  1  SHALL mark a valid ALU result this cycle.
REQ-005 alu_num_in  input  3  SHALL be the ALU destination register number.
REQ-006 alu_data_in  input  16  SHALL be the ALU result data.
REQ-007 alu_ready_out  output  1  SHALL indicate the queue accepts an ALU result this cycle.
REQ-008 mem_valid_in, mem_num_in[2:0], mem_data_in[15:0] (inputs) and mem_ready_out (output) SHALL be the same handshake for the load/memory unit.
REQ-009 write0_out / write1_out  output  1 each  SHALL drive the regfile write enables.
REQ-010 num_write0_out / num_write1_out  output  3 each  SHALL drive the regfile write register numbers.
REQ-011 data_write0_out / data_write1_out  output  16 each  SHALL drive the regfile write data.
REQ-012 count_out  output  $clog2(DEPTH)+1  SHALL report the number of occupied entries.
REQ-013 pending_mask_out  output  8  SHALL exist only under WB_PENDING_MASK_EN (REQ-027).

Function
REQ-014 The queue SHALL be a circular FIFO of DEPTH entries {num, data}, with head/tail pointers wrapping modulo DEPTH.
REQ-015 Both ready outputs SHALL be 1 iff registered count <= DEPTH-2, independent of this cycle's drain or valid inputs (no combinational valid->ready path).
REQ-016 A transfer SHALL occur on an edge where valid and ready are both 1; when both units transfer in the same cycle, the ALU entry SHALL be enqueued first (older), the MEM entry second.
REQ-017 Enqueue-to-write latency SHALL be one cycle minimum: an entry accepted at edge N appears on the write ports during cycle N+1 and commits to the regfile at edge N+2. There is no empty-queue bypass.
REQ-018 write0_out SHALL be 1 iff count >= 1, presenting the head entry combinationally from storage.
REQ-019 write1_out SHALL be 1 iff count >= 2 and entry[head+1].num != entry[head].num, presenting entry head+1.
REQ-020 When the two oldest entries target the same register, only the head SHALL drain that cycle; the younger SHALL drain on a later cycle, so program order is preserved.
REQ-021 Entries drained per edge SHALL equal write0_out + write1_out; head advances by that amount modulo DEPTH.
REQ-022 count SHALL update as count + enqueued - drained on each edge; simultaneous enqueue and drain SHALL be exact, including at wrap-around.
REQ-023 count SHALL never exceed DEPTH. Input valid while not ready SHALL be ignored, and the producer SHALL hold its data.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear count, head and tail to 0, force write0_out and write1_out to 0, and discard all buffered entries, including mid-drain.
REQ-025 After release, both ready outputs SHALL read 1 and count_out SHALL read 0. Entry data storage need not be reset.
REQ-026 No write enable SHALL pulse in the first cycle after reset release.

Configuration
REQ-027 Macro WB_PENDING_MASK_EN: when defined, pending_mask_out bit r SHALL be 1 iff any occupied entry targets register r (combinational from storage; 0 in reset). When undefined, the port and its logic SHALL be absent.

Structure
REQ-028 Package kl_pkg SHALL hold reg_num_t (3 bits), word_t (16 bits), NUM_REGS = 8, and the wb_entry_t struct {reg_num_t num; word_t data}.
REQ-029 No sub-module is required. Storage, pointers and the drain selector SHALL be implemented inline in writeback_queue.

Verification
REQ-030 Single ALU result r3=0x1234 accepted at edge 1 -> write0_out=1, num=3, data=0x1234 during cycle 2, write1_out=0. Queue is empty after edge 2.
REQ-031 Same-cycle ALU r1=0xAAAA and MEM r2=0x5555 -> next cycle write0 drives r1/0xAAAA and write1 drives r2/0x5555, both drained in one edge.
REQ-032 Same-cycle ALU r4=0x0001 and MEM r4=0x0002 -> cycle N+1 shows only write0 with 0x0001. Cycle N+2 shows write0 with 0x0002. Final r4=0x0002.
REQ-033 Fill to DEPTH-1 with drain stalled by same-register pairs -> both ready outputs drop to 0 and count_out never exceeds DEPTH.
REQ-034 Run 3*DEPTH back-to-back dual enqueues across pointer wrap -> regfile contents match a program-order reference model and no entry is lost or duplicated.
REQ-035 Assert rst_n mid-operation with 3 entries queued -> write enables drop to 0 asynchronously, count_out=0, ready outputs=1 after release, and no stale write occurs. With WB_PENDING_MASK_EN defined, pending_mask_out=0x00.
